// File: rtl/program_sequencer.sv
// Program sequencer for the multicycle datapath: 16-word program memory,
// STEP/RUN-paced one-cycle datapath ticks, PC advance on word consumption, HALT stop.
module program_sequencer #(
  parameter int         RATE_DIV  = 25_000_000,
  parameter logic [9:0] HALT_WORD = 10'h3FF
) (
  input  logic       i_clk50mhz,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_step,
  input  logic       i_restart,
  input  logic       i_prog_we,
  input  logic [3:0] i_prog_addr,
  input  logic [9:0] i_prog_data,
  input  logic       i_irin,
  input  logic       i_ext,
  input  logic       i_done,
  output logic [9:0] o_data_out,
  output logic       o_tick,
  output logic [3:0] o_pc,
  output logic [7:0] o_instr_cnt,
  output logic       o_halted,
  output logic       o_busy
);

  localparam int PW = $clog2(RATE_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_pace, w_pace_next;
  logic          r_tick;
  logic [3:0]    r_pc;
  logic [7:0]    r_cnt;
  logic [9:0]    r_mem [16];
  logic          w_req_raw, w_req, w_is_halt;
  logic [9:0]    w_data_out;

  assign w_data_out = r_mem[r_pc];
  assign w_is_halt  = i_irin && (w_data_out == HALT_WORD);

  always_comb begin
    w_state_next = r_state;
    w_pace_next  = r_pace;
    w_req_raw    = 1'b0;
    w_req        = 1'b0;
    if (i_restart) begin
      w_state_next = S_IDLE;
      w_pace_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Entering RUN behaves as a pace counter already at zero.
          if (i_run) begin
            w_req_raw    = 1'b1;
            w_pace_next  = PW'(RATE_DIV - 1);
            w_state_next = S_RUN;
          end else if (i_step) begin
            w_req_raw = 1'b1;
          end
        end
        S_RUN: begin
          if (!i_run) begin
            w_state_next = S_IDLE;
            w_pace_next  = '0;
          end else if (r_pace == '0) begin
            w_req_raw   = 1'b1;
            w_pace_next = PW'(RATE_DIV - 1);
          end else begin
            w_pace_next = r_pace - PW'(1);
          end
        end
        default: ;
      endcase
      if (w_req_raw) begin
        if (w_is_halt) begin
          w_state_next = S_HALT;
          w_pace_next  = '0;
        end else begin
          w_req = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pace  <= '0;
      r_tick  <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pace  <= w_pace_next;
      r_tick  <= w_req;
      if (i_restart) begin
        r_pc  <= '0;
        r_cnt <= '0;
      end else if (r_tick) begin
        // The datapath has sampled the bus during this tick; now advance.
        if (i_irin || i_ext)
          r_pc <= r_pc + 4'd1;
        if (i_done && (r_cnt != 8'hFF))
          r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk50mhz) begin
    if (i_prog_we && (r_state != S_RUN))
      r_mem[i_prog_addr] <= i_prog_data;
  end

  assign o_data_out  = w_data_out;
  assign o_tick      = r_tick;
  assign o_pc        = r_pc;
  assign o_instr_cnt = r_cnt;
  assign o_halted    = (r_state == S_HALT);
  assign o_busy      = (r_state == S_RUN);

endmodule
